// File: rtl/pls_tx_framer.sv
// pls_tx_framer - 10BASE-T PLS transmitter.
//
// Takes DATA_W-bit words from the MAC over a valid/ready handshake,
// serialises them LSB-first and Manchester-encodes them onto the
// differential pair. Each frame ends with TP_IDL followed by mandatory
// silence. Normal link pulses (NLP) are sent while the line is idle.
// Runs at twice the bit rate, so one clock cycle is one half-bit.
//
// Configuration macro: PLS_TX_PREAMBLE_EN
//   defined   : PREAMBLE state is built; 7x 0x55 + 0xD5 is generated here.
//   undefined : upstream supplies preamble/SFD as ordinary data words.
//
// Ports:
//   clk_20mhz    in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   tx_data      in   [DATA_W] word to send
//   tx_valid     in   tx_data / tx_last valid
//   tx_last      in   word is the final word of the frame
//   tx_ready     out  word accepted when tx_valid is also high
//   tx_underrun  out  one-cycle pulse, frame aborted for lack of a word
//   txd_out_p    out  positive line output (registered)
//   txd_out_n    out  negative line output (registered)
//   txbusy       out  high whenever the framer is not idle (registered)
module pls_tx_framer #(
  parameter int NLP_PERIOD     = 320000,
  parameter int NLP_WIDTH      = 2,
  parameter int DATA_W         = 8,
  parameter int IDL_CYCLES     = 12,
  parameter int SILENCE_CYCLES = 48,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic              clk_20mhz,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              txd_out_p,
  output logic              txd_out_n,
  output logic              txbusy
);

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PH_MAX = (IDL_CYCLES > SILENCE_CYCLES) ? IDL_CYCLES : SILENCE_CYCLES;
  localparam int NLP_W  = cnt_w(NLP_PERIOD);
  localparam int PUL_W  = cnt_w(NLP_WIDTH);
  localparam int BIT_W  = cnt_w(DATA_W);
  localparam int PH_W   = cnt_w(PH_MAX);

  localparam logic [NLP_W-1:0] NLP_LAST = NLP_W'(NLP_PERIOD - 1);
  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(NLP_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [PH_W-1:0]  IDL_LAST = PH_W'(IDL_CYCLES - 1);
  localparam logic [PH_W-1:0]  SIL_LAST = PH_W'(SILENCE_CYCLES - 1);

`ifdef PLS_TX_PREAMBLE_EN
  localparam int PRE_BITS = 8 * (PREAMBLE_BYTES + 1);
  localparam int PRE_W    = cnt_w(PRE_BITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_BITS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
`ifdef PLS_TX_PREAMBLE_EN
    S_PREAMBLE = 3'd1,
`endif
    S_DATA     = 3'd2,
    S_IDL      = 3'd3,
    S_SILENCE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [NLP_W-1:0]  nlp_cnt_q, nlp_cnt_d;
  logic [PUL_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic              lit_q, lit_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              half_q, half_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              last_q, last_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic              underrun_q, underrun_d;
  logic              busy_q, busy_d;
  logic              txd_out_p_q, txd_out_p_d;
  logic              txd_out_n_q, txd_out_n_d;
  logic              txen_s;
  logic              txd_s;
  logic              ready_s;

`ifdef PLS_TX_PREAMBLE_EN
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              pre_bit_s;

  // 0x55 LSB-first is 1,0,1,0,...; the SFD 0xD5 differs only in its final bit (1).
  assign pre_bit_s = (pre_cnt_q == PRE_LAST) | ~pre_cnt_q[0];
`endif

  // Next-state, counter and line-level decode.
  always_comb begin
    state_d     = state_q;
    nlp_cnt_d   = nlp_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    lit_d       = 1'b0;
    bit_idx_d   = bit_idx_q;
    half_d      = half_q;
    shift_d     = shift_q;
    last_d      = last_q;
    ph_cnt_d    = ph_cnt_q;
    underrun_d  = 1'b0;
    txen_s      = 1'b0;
    txd_s       = 1'b0;
    ready_s     = 1'b0;
`ifdef PLS_TX_PREAMBLE_EN
    pre_cnt_d   = pre_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        // lit_q still covers the last cycle of a pulse on the line.
        ready_s = ~lit_q & (pulse_cnt_q == '0);
        if (ready_s && tx_valid) begin
          // A handshake wins over a pulse that would start this same edge.
          shift_d   = tx_data;
          last_d    = tx_last;
          nlp_cnt_d = '0;
          bit_idx_d = '0;
          half_d    = 1'b0;
`ifdef PLS_TX_PREAMBLE_EN
          pre_cnt_d = '0;
          state_d   = S_PREAMBLE;
`else
          state_d   = S_DATA;
`endif
        end else if (nlp_cnt_q == NLP_LAST) begin
          nlp_cnt_d   = '0;
          lit_d       = 1'b1;
          pulse_cnt_d = PUL_LAST;
        end else begin
          nlp_cnt_d = nlp_cnt_q + NLP_W'(1);
          if (pulse_cnt_q != '0) begin
            lit_d       = 1'b1;
            pulse_cnt_d = pulse_cnt_q - PUL_W'(1);
          end else begin
            lit_d = 1'b0;
          end
        end
      end

`ifdef PLS_TX_PREAMBLE_EN
      S_PREAMBLE: begin
        txen_s = 1'b1;
        txd_s  = half_q ? pre_bit_s : ~pre_bit_s;
        if (half_q) begin
          half_d = 1'b0;
          if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d = '0;
            state_d   = S_DATA;
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
        end else begin
          half_d = 1'b1;
        end
      end
`endif

      S_DATA: begin
        txen_s = 1'b1;
        txd_s  = half_q ? shift_q[0] : ~shift_q[0];
        if (!half_q) begin
          half_d = 1'b1;
        end else begin
          half_d = 1'b0;
          if (bit_idx_q != BIT_LAST) begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
          end else if (last_q) begin
            bit_idx_d = '0;
            ph_cnt_d  = '0;
            state_d   = S_IDL;
          end else begin
            // Word boundary: the next word must be here now, there is no gap bit.
            ready_s   = 1'b1;
            bit_idx_d = '0;
            if (tx_valid) begin
              shift_d = tx_data;
              last_d  = tx_last;
            end else begin
              underrun_d = 1'b1;
              ph_cnt_d   = '0;
              state_d    = S_IDL;
            end
          end
        end
      end

      S_IDL: begin
        txen_s = 1'b1;
        txd_s  = 1'b1;
        if (ph_cnt_q == IDL_LAST) begin
          ph_cnt_d = '0;
          state_d  = S_SILENCE;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      S_SILENCE: begin
        if (ph_cnt_q == SIL_LAST) begin
          ph_cnt_d  = '0;
          nlp_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    txd_out_p_d = txen_s ? txd_s : lit_d;
    txd_out_n_d = txen_s & ~txd_s;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_20mhz) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      nlp_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      lit_q       <= 1'b0;
      bit_idx_q   <= '0;
      half_q      <= 1'b0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      ph_cnt_q    <= '0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      txd_out_p_q <= 1'b0;
      txd_out_n_q <= 1'b0;
`ifdef PLS_TX_PREAMBLE_EN
      pre_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      nlp_cnt_q   <= nlp_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      lit_q       <= lit_d;
      bit_idx_q   <= bit_idx_d;
      half_q      <= half_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      ph_cnt_q    <= ph_cnt_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
      txd_out_p_q <= txd_out_p_d;
      txd_out_n_q <= txd_out_n_d;
`ifdef PLS_TX_PREAMBLE_EN
      pre_cnt_q   <= pre_cnt_d;
`endif
    end
  end

  // Ready is held low during reset so every output reads 0 while rst_i is high.
  assign tx_ready    = ready_s & ~rst_i;
  assign tx_underrun = underrun_q;
  assign txbusy      = busy_q;
  assign txd_out_p   = txd_out_p_q;
  assign txd_out_n   = txd_out_n_q;

endmodule

// File: tb/tb_pls_tx_framer.sv
`timescale 1ns/1ps
module tb_pls_tx_framer;

  localparam int NLP_PERIOD     = 200;
  localparam int NLP_WIDTH      = 2;
  localparam int DATA_W         = 8;
  localparam int IDL_CYCLES     = 12;
  localparam int SILENCE_CYCLES = 48;
  localparam int PREAMBLE_BYTES = 7;
  localparam int HALF_PERIOD    = 25;
`ifdef PLS_TX_PREAMBLE_EN
  localparam int PRE_CYC = 16 * (PREAMBLE_BYTES + 1);
`else
  localparam int PRE_CYC = 0;
`endif

  logic              clk_20mhz = 1'b0;
  logic              rst_i     = 1'b1;
  logic [DATA_W-1:0] tx_data   = '0;
  logic              tx_valid  = 1'b0;
  logic              tx_last   = 1'b0;
  logic              tx_ready;
  logic              tx_underrun;
  logic              txd_out_p;
  logic              txd_out_n;
  logic              txbusy;

  pls_tx_framer #(
    .NLP_PERIOD    (NLP_PERIOD),
    .NLP_WIDTH     (NLP_WIDTH),
    .DATA_W        (DATA_W),
    .IDL_CYCLES    (IDL_CYCLES),
    .SILENCE_CYCLES(SILENCE_CYCLES),
    .PREAMBLE_BYTES(PREAMBLE_BYTES)
  ) dut (
    .clk_20mhz  (clk_20mhz),
    .rst_i      (rst_i),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .txd_out_p  (txd_out_p),
    .txd_out_n  (txd_out_n),
    .txbusy     (txbusy)
  );

  always #HALF_PERIOD clk_20mhz = ~clk_20mhz;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle observation after a frame starts: {p, n, busy, underrun}.
  logic [3:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         idle_k = 0;     // cycles since line reference (reset / silence exit)

  logic [DATA_W-1:0] fw [4];
  time               last_acc_t;
  int                gap_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One bit on the wire: first half drives !b, second half drives b.
  function automatic void push_bit(input logic b, input logic und);
    exp_q.push_back({~b, b, 1'b1, 1'b0});
    exp_q.push_back({b, ~b, 1'b1, und});
  endfunction

  function automatic void push_word(input logic [DATA_W-1:0] w, input bit first,
                                    input bit final_w, input bit und);
    logic [7:0] pb;
    if (first) begin
      exp_q.push_back(4'b0010);
      if (PRE_CYC != 0) begin
        for (int by = 0; by <= PREAMBLE_BYTES; by++) begin
          pb = (by == PREAMBLE_BYTES) ? 8'hD5 : 8'h55;
          for (int i = 0; i < 8; i++) push_bit(pb[i], 1'b0);
        end
      end
    end
    for (int i = 0; i < DATA_W; i++) push_bit(w[i], und && (i == DATA_W - 1));
    if (final_w) begin
      for (int i = 0; i < IDL_CYCLES; i++) exp_q.push_back(4'b1010);
      for (int s = 0; s < SILENCE_CYCLES; s++)
        exp_q.push_back({2'b00, (s != SILENCE_CYCLES - 1), 1'b0});
    end
  endfunction

  // Monitor: compares against the frame queue, or the idle NLP model when empty.
  always @(negedge clk_20mhz) begin : monitor
    logic [3:0] e;
    logic       pe;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("line", {28'd0, txd_out_p, txd_out_n, txbusy, tx_underrun}, {28'd0, e});
        if (exp_q.size() == 0) idle_k = 1;
      end else begin
        pe = (idle_k >= NLP_PERIOD) && ((idle_k % NLP_PERIOD) < NLP_WIDTH);
        check("idle", {27'd0, txd_out_p, txd_out_n, txbusy, tx_underrun, tx_ready},
              {27'd0, pe, 1'b0, 1'b0, 1'b0, ~pe});
        idle_k++;
      end
    end
  end

  task automatic send_word(input logic [DATA_W-1:0] w, input bit first, input bit lst,
                           input bit und, output bit ok);
    int waited;
    @(negedge clk_20mhz);
    tx_data  = w;
    tx_valid = 1'b1;
    tx_last  = lst;
    #1;
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 1000) begin
      @(negedge clk_20mhz);
      #1;
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      check("ready_wait", {31'd0, tx_ready}, 32'd1);
      tx_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk_20mhz);
      push_word(w, first, lst || und, und);
      if (!first) check("ready_spacing", 32'(($time - last_acc_t) / (2 * HALF_PERIOD)), 32'(gap_exp));
      gap_exp    = first ? (PRE_CYC + 2 * DATA_W) : (2 * DATA_W);
      last_acc_t = $time;
      #1;
      tx_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk_20mhz);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input int nw, input bit und);
    bit ok;
    for (int i = 0; i < nw; i++) begin
      send_word(fw[i], i == 0, (i == nw - 1) && !und, (i == nw - 1) && und, ok);
      if (!ok) break;
    end
    wait_drain();
  endtask

  task automatic do_reset();
    @(negedge clk_20mhz);
    mon_en   = 1'b0;
    exp_q.delete();
    rst_i    = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk_20mhz);
    check("reset_mid", {27'd0, tx_ready, tx_underrun, txbusy, txd_out_p, txd_out_n}, 32'd0);
    rst_i = 1'b0;
    #1;
    idle_k = 1;
    mon_en = 1'b1;
  endtask

  initial begin : watchdog
    #(2 * HALF_PERIOD * 80000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int nw;
    bit und;
    last_acc_t = 0;
    gap_exp    = 0;

    // Reset held three cycles: every output must read 0.
    rst_i = 1'b1;
    repeat (3) begin
      @(negedge clk_20mhz);
      check("reset_outputs", {27'd0, tx_ready, tx_underrun, txbusy, txd_out_p, txd_out_n}, 32'd0);
    end
    rst_i = 1'b0;
    #1;
    idle_k = 1;
    mon_en = 1'b1;

    // Idle through two link pulses.
    repeat (2 * NLP_PERIOD + 10) @(negedge clk_20mhz);

    // tx_valid raised during a link pulse; frame 0xA5 follows the pulse.
    begin : wait_pulse
      int n;
      n = 0;
      while (txd_out_p !== 1'b1 && n < 2 * NLP_PERIOD) begin
        @(negedge clk_20mhz);
        n++;
      end
      check("pulse_seen", {31'd0, txd_out_p}, 32'd1);
    end
    fw[0] = 8'hA5;
    send_frame(1, 1'b0);

    // Three words streamed back to back.
    fw[0] = 8'h01; fw[1] = 8'h02; fw[2] = 8'h03;
    send_frame(3, 1'b0);

    // Second word withheld at the boundary.
    fw[0] = 8'h3C;
    send_frame(1, 1'b1);

    // Randomised frames with random idle gaps (gaps cross link pulses).
    for (int f = 0; f < 30; f++) begin
      nw  = $urandom_range(1, 4);
      und = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) fw[i] = DATA_W'($urandom);
      send_frame(nw, und);
      repeat ($urandom_range(0, 250)) @(negedge clk_20mhz);
    end

    // Reset in the middle of a frame, then the next pulse a full period later.
    fw[0] = 8'hE7;
    send_word(fw[0], 1'b1, 1'b0, 1'b0, ok);
    repeat (PRE_CYC + 5) @(negedge clk_20mhz);
    do_reset();
    repeat (NLP_PERIOD + 10) @(negedge clk_20mhz);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pls_tx_framer.md
# pls_tx_framer

Parametrised 10BASE-T PLS transmitter. Accepts DATA_W-bit words over a valid/ready handshake and serialises them LSB-first. Manchester-encodes the bits onto the differential twisted-pair outputs, with optional automatic preamble/SFD insertion. Appends TP_IDL, enforces post-frame silence, and emits normal link pulses (NLP) while idle. Sits between the MAC transmit path and the TX line driver, clocked at 2× bit rate (20 MHz, one half-bit per cycle).

## Interface

- NLP_PERIOD, 320000: idle cycles between link pulses (16 ms).
- NLP_WIDTH, 2: link pulse high time in cycles (100 ns).
- DATA_W, 8: word width, ≥1; bits sent LSB-first.
- IDL_CYCLES, 12: TP_IDL high time in cycles after the last bit.
- SILENCE_CYCLES, 48: mandatory quiet cycles after TP_IDL.
- PREAMBLE_BYTES, 7: count of 0x55 bytes before the SFD. Used only with preamble insertion.

- clk_20mhz  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- tx_data  in  DATA_W  word to send.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_last  in  1  word is the final word of the frame.
- tx_ready  out  1  word accepted this cycle when tx_valid is also high.
- tx_underrun  out  1  one-cycle pulse; frame aborted because the next word was missing.
- txd_out_p  out  1  positive line output.
- txd_out_n  out  1  negative line output.
- txbusy  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, PREAMBLE, DATA, IDL, SILENCE.
- Line encoding (all registered):
  - txd_out_p = txen ? txd : lit.
  - txd_out_n = txen & !txd.
  - Quiet line: both outputs low.
- Manchester: each bit occupies 2 cycles. First half drives txd = !bit, second half txd = bit (logical 1 = low→high at mid-bit).
- IDLE:
  - NLP counter increments each cycle.
  - At NLP_PERIOD-1: counter clears and lit = 1 for NLP_WIDTH cycles.
  - tx_ready = 1 when no pulse is in progress.
  - Handshake moves the word into the shifter, latches tx_last, clears the NLP counter, and enters PREAMBLE (or DATA without preamble).
- PREAMBLE: sends PREAMBLE_BYTES × 0x55 then 0xD5, LSB-first, with the first word held. Then DATA.
- DATA:
  - Shifts the word out.
  - tx_ready = 1 only in the second-half cycle of bit DATA_W-1, and only when the latched last flag is 0.
  - Handshake there loads the next word seamlessly with no gap bit.
  - If tx_valid = 0 there: pulse tx_underrun, go to IDL.
  - If the last flag is set: go to IDL after its final half-bit.
- IDL: txen = 1, txd = 1 for IDL_CYCLES, then txen = 0 and go to SILENCE.
- SILENCE: outputs low for SILENCE_CYCLES. tx_ready = 0. Then IDLE with the NLP counter at 0.
- tx_ready is combinational from state/counters, never from tx_valid. tx_valid without tx_ready is ignored and holds.
- Reset: state IDLE, all counters 0, txen = lit = txd = 0. All outputs 0: tx_ready, tx_underrun, txbusy, txd_out_p, txd_out_n. Reset mid-frame truncates immediately with no IDL.
- Counters sized by $clog2 of their maximum. The bit index wraps at DATA_W-1.

## Timing

- Word accepted in IDLE at edge N: first encoded half-bit on the line at edge N+1.
- Gap-free stream: line toggles every half-bit with no missing cycles at word boundaries.
- NLP exactly NLP_PERIOD cycles after the previous pulse start or after SILENCE exit.
- tx_valid arriving during a pulse waits; tx_ready rises the cycle after the pulse ends.
- Frame length (preamble on):
  - 16×(PREAMBLE_BYTES+1) + 2×DATA_W×words cycles of data.
  - Plus IDL_CYCLES + SILENCE_CYCLES.
  - txbusy covers all of it.
- tx_underrun and entry to IDL occur on the same edge.

## Configuration

- PLS_TX_PREAMBLE_EN defined: PREAMBLE state is built. Preamble+SFD are generated internally, and the upstream supplies only the frame from the destination address on.
- Not defined: PREAMBLE state and its counter are removed. IDLE goes straight to DATA, and upstream supplies preamble/SFD as ordinary words. PREAMBLE_BYTES is ignored.

## Test plan

- Reset held 3 cycles, then idle 320000 cycles:
  - All outputs 0 through reset.
  - txd_out_p high 2 cycles at cycle 320000, txd_out_n stays 0.
- DATA_W=8, macro on, send 0xA5 (tx_last = 1):
  - 128 cycles of 0x55×7 + 0xD5 encoding.
  - Then 0xA5 LSB-first: p pattern 0,1 / 1,0 / 0,1 / 1,0 / 1,0 / 0,1 / 1,0 / 0,1.
  - Then 12 cycles p = 1, 48 cycles low, then txbusy = 0.
- Three words 0x01, 0x02, 0x03 (last on 0x03), tx_valid held:
  - tx_ready pulses exactly at word boundaries 16 cycles apart.
  - No line gap.
- Second word withheld at the boundary:
  - tx_underrun = 1 for one cycle.
  - IDL starts the same edge, and the line never encodes a stale word.
- tx_valid raised during an NLP:
  - tx_ready stays 0 until the pulse ends.
  - Frame starts the next cycle.
- rst_i asserted mid-DATA:
  - Next cycle: all outputs 0, state IDLE.
  - Next NLP 320000 cycles later.
